mips_divider: RTL



---
 rtl/mips_div_pkg.sv | 15 +
 rtl/mips_divider_if.sv | 29 ++
 rtl/mips_div_step.sv | 30 +++
 rtl/mips_divider.sv | 124 ++++++++++++
 4 files changed

// File: rtl/mips_div_pkg.sv
// Shared types and constants for the multi-cycle MIPS DIV/DIVU unit.
package mips_div_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = $clog2(DIV_WIDTH) + 1;

  localparam logic [DIV_WIDTH-1:0] DIV_BY_ZERO_Q = '1;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_FIX  = 2'd2
  } div_state_t;

endpackage

// File: rtl/mips_divider_if.sv
// Request/result bundle between EX-stage control (master) and the divider (slave).
interface mips_divider_if
  import mips_div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
);

  logic             start;
  logic             signed_op;
  logic             cancel;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, signed_op, cancel, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, signed_op, cancel, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/mips_div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract the divisor.
module mips_div_step
  import mips_div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] prem,
  input  logic             dbit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] prem_next,
  output logic             qbit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;
  logic           borrow;
  logic           unused_diff_msb;

  always_comb begin
    // NOTE: every variable is assigned on every pass, so no latch is inferred.
    shifted   = {prem, dbit};
    {borrow, diff} = {1'b0, shifted} - {2'b00, divisor};
    qbit      = ~borrow;
    // Whichever value survives is below the divisor, so it fits in WIDTH bits.
    prem_next = borrow ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
  end

  assign unused_diff_msb = diff[WIDTH];

endmodule

// File: rtl/mips_divider.sv
// Multi-cycle restoring divider for DIV/DIVU: fixed 33-cycle latency, result on a done pulse.
module mips_divider
  import mips_div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input logic            clk,
  input logic            rst,
  mips_divider_if.slave  bus
);

  localparam logic [DIV_CNT_W-1:0] LAST_STEP = DIV_CNT_W'(WIDTH - 1);

  div_state_t           state;
  logic [DIV_CNT_W-1:0] cnt;
  logic [WIDTH-1:0]     prem;
  logic [WIDTH-1:0]     dq;      // dividend bits shift out the top, quotient bits shift in
  logic [WIDTH-1:0]     dvs;
  logic                 neg_q;
  logic                 neg_r;

  logic                 busy_q;
  logic                 done_q;
  logic [WIDTH-1:0]     quot_q;
  logic [WIDTH-1:0]     rem_q;
  logic                 dbz_q;

  logic                 a_neg;
  logic                 b_neg;
  logic [WIDTH-1:0]     a_mag;
  logic [WIDTH-1:0]     b_mag;
  logic [WIDTH-1:0]     prem_next;
  logic                 qbit;
  logic [WIDTH-1:0]     q_fix;
  logic [WIDTH-1:0]     r_fix;

  assign a_neg = bus.signed_op & bus.dividend[WIDTH-1];
  assign b_neg = bus.signed_op & bus.divisor[WIDTH-1];
  assign a_mag = a_neg ? -bus.dividend : bus.dividend;
  assign b_mag = b_neg ? -bus.divisor  : bus.divisor;

  // Negating |dividend| restores the original bits, which is also the divide-by-zero remainder.
  assign q_fix = neg_q ? -dq   : dq;
  assign r_fix = neg_r ? -prem : prem;

  mips_div_step #(.WIDTH(WIDTH)) u_step (
    .prem      (prem),
    .dbit      (dq[WIDTH-1]),
    .divisor   (dvs),
    .prem_next (prem_next),
    .qbit      (qbit)
  );

  // NOTE: asynchronous reset, and all sequential state is written with non-blocking assignments.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= DIV_IDLE;
      cnt    <= '0;
      prem   <= '0;
      dq     <= '0;
      dvs    <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      quot_q <= '0;
      rem_q  <= '0;
      dbz_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        DIV_IDLE: begin
          if (bus.start && !bus.cancel) begin
            state  <= DIV_RUN;
            busy_q <= 1'b1;
            cnt    <= '0;
            prem   <= '0;
            dq     <= a_mag;
            dvs    <= b_mag;
            neg_q  <= a_neg ^ b_neg;
            neg_r  <= a_neg;
          end
        end
        DIV_RUN: begin
          if (bus.cancel) begin
            state  <= DIV_IDLE;
            busy_q <= 1'b0;
          end else begin
            prem <= prem_next;
            dq   <= {dq[WIDTH-2:0], qbit};
            cnt  <= cnt + 1'b1;
            if (cnt == LAST_STEP) state <= DIV_FIX;
          end
        end
        DIV_FIX: begin
          state  <= DIV_IDLE;
          busy_q <= 1'b0;
          if (!bus.cancel) begin
            done_q <= 1'b1;
            rem_q  <= r_fix;
            if (dvs == '0) begin
              quot_q <= DIV_BY_ZERO_Q;
              dbz_q  <= 1'b1;
            end else begin
              quot_q <= q_fix;
              dbz_q  <= 1'b0;
            end
          end
        end
        default: begin
          state  <= DIV_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.quotient    = quot_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;

endmodule
